// File: rtl/gesture_on_off_detect.sv
// Turns per-frame gesture classes into one-cycle is_on/is_off pulses after a stable hold.
// Latency: pulse registered, high for the cycle after the confirming frame edge. No backpressure.
// Only frame_valid cycles advance the FSM; a cooldown and a release gate every retrigger.
module gesture_on_off_detect #(
    parameter int HOLD_FRAMES     = 8,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [1:0] gesture,
    output logic       is_on,
    output logic       is_off,
    output logic [2:0] state,
    output logic [7:0] hold_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TRACK    = 3'd1;
    localparam logic [2:0] S_COOLDOWN = 3'd2;
    localparam logic [2:0] S_RELEASE  = 3'd3;

    localparam logic [7:0] HOLD_N = 8'(HOLD_FRAMES);
    localparam logic [7:0] COOL_N = 8'(COOLDOWN_FRAMES);
    // With no cooldown the fire goes straight to waiting for the hand to drop.
    localparam logic [2:0] FIRE_STATE = (COOLDOWN_FRAMES == 0) ? S_RELEASE : S_COOLDOWN;

    logic [1:0] cand;
    logic [7:0] count_inc;
    logic       gest_valid;

    assign count_inc  = hold_count + 8'd1;
    assign gest_valid = (gesture == 2'd1) || (gesture == 2'd2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cand       <= 2'd0;
            hold_count <= 8'd0;
            is_on      <= 1'b0;
            is_off     <= 1'b0;
        end else begin
            is_on  <= 1'b0;
            is_off <= 1'b0;
            if (frame_valid) begin
                case (state)
                    S_IDLE: begin
                        if (gest_valid) begin
                            cand <= gesture;
                            if (HOLD_FRAMES == 1) begin
                                is_on      <= (gesture == 2'd1);
                                is_off     <= (gesture == 2'd2);
                                hold_count <= 8'd0;
                                state      <= FIRE_STATE;
                            end else begin
                                hold_count <= 8'd1;
                                state      <= S_TRACK;
                            end
                        end
                    end
                    S_TRACK: begin
                        if (!gest_valid) begin
                            hold_count <= 8'd0;
                            state      <= S_IDLE;
                        end else if (gesture != cand) begin
                            // Switching hands restarts the hold directly on the new gesture.
                            cand       <= gesture;
                            hold_count <= 8'd1;
                        end else if (count_inc == HOLD_N) begin
                            is_on      <= (cand == 2'd1);
                            is_off     <= (cand == 2'd2);
                            hold_count <= 8'd0;
                            state      <= FIRE_STATE;
                        end else begin
                            hold_count <= count_inc;
                        end
                    end
                    S_COOLDOWN: begin
                        if (count_inc == COOL_N) begin
                            hold_count <= 8'd0;
                            state      <= S_RELEASE;
                        end else begin
                            hold_count <= count_inc;
                        end
                    end
                    S_RELEASE: begin
                        if (!gest_valid) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        hold_count <= 8'd0;
                        state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gesture_on_off_detect.sv
// Directed bench for gesture_on_off_detect: vector table plus hand-written corner sequences.
module tb_gesture_on_off_detect;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_valid = 1'b0;
    logic [1:0] gesture = 2'd0;

    logic       is_on, is_off, is_on2, is_off2;
    logic [2:0] state, state2;
    logic [7:0] hold_count, hold_count2;

    always #5 clock = ~clock;

    gesture_on_off_detect #(.HOLD_FRAMES(8), .COOLDOWN_FRAMES(15)) dut (
        .clock(clock), .reset(reset), .frame_valid(frame_valid), .gesture(gesture),
        .is_on(is_on), .is_off(is_off), .state(state), .hold_count(hold_count)
    );

    gesture_on_off_detect #(.HOLD_FRAMES(1), .COOLDOWN_FRAMES(0)) dut_min (
        .clock(clock), .reset(reset), .frame_valid(frame_valid), .gesture(gesture),
        .is_on(is_on2), .is_off(is_off2), .state(state2), .hold_count(hold_count2)
    );

    typedef struct {
        logic       fv;
        logic [1:0] g;
        logic       on;
        logic       off;
        logic [2:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic fv, input logic [1:0] g, input logic on, input logic off,
                       input logic [2:0] st, input logic [7:0] cnt);
        vec_t v;
        v.fv = fv; v.g = g; v.on = on; v.off = off; v.st = st; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Frame followed by an idle cycle whose gesture differs; the idle cycle must change nothing.
    task automatic add_frame(input logic [1:0] g, input logic on, input logic off,
                             input logic [2:0] st, input logic [7:0] cnt);
        add(1'b1, g, on, off, st, cnt);
        add(1'b0, g ^ 2'd3, 1'b0, 1'b0, st, cnt);
    endtask

    task automatic cycle(input logic fv, input logic [1:0] g);
        @(negedge clock);
        frame_valid = fv;
        gesture     = g;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        frame_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk("rst.state", state, 0);
        chk("rst.count", hold_count, 0);
        chk("rst.on_off", {is_on, is_off}, 0);
        chk("rst.min_state", state2, 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    int ons, offs;

    initial begin
        // Basic ON with back-to-back strobes.
        for (int i = 1; i <= 7; i++) add(1'b1, 2'd1, 1'b0, 1'b0, 3'd1, 8'(i));
        add(1'b1, 2'd1, 1'b1, 1'b0, 3'd2, 8'd0);
        // Pulse width, then frame_valid low with gesture toggling.
        add(1'b0, 2'd1, 1'b0, 1'b0, 3'd2, 8'd0);
        add(1'b0, 2'd2, 1'b0, 1'b0, 3'd2, 8'd0);
        add(1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 8'd0);
        add(1'b0, 2'd3, 1'b0, 1'b0, 3'd2, 8'd0);
        for (int i = 1; i <= 14; i++) add_frame(2'd2, 1'b0, 1'b0, 3'd2, 8'(i));
        add_frame(2'd2, 1'b0, 1'b0, 3'd3, 8'd0);
        add_frame(2'd3, 1'b0, 1'b0, 3'd0, 8'd0);
        // Interrupted hold.
        for (int i = 1; i <= 5; i++) add_frame(2'd1, 1'b0, 1'b0, 3'd1, 8'(i));
        add_frame(2'd0, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int i = 1; i <= 7; i++) add_frame(2'd1, 1'b0, 1'b0, 3'd1, 8'(i));
        add_frame(2'd1, 1'b1, 1'b0, 3'd2, 8'd0);
        for (int i = 1; i <= 14; i++) add_frame(2'd0, 1'b0, 1'b0, 3'd2, 8'(i));
        add_frame(2'd0, 1'b0, 1'b0, 3'd3, 8'd0);
        add_frame(2'd0, 1'b0, 1'b0, 3'd0, 8'd0);
        // Gesture switch: direct restart on frame 5, OFF on frame 12.
        for (int i = 1; i <= 4; i++) add_frame(2'd1, 1'b0, 1'b0, 3'd1, 8'(i));
        for (int i = 1; i <= 7; i++) add_frame(2'd2, 1'b0, 1'b0, 3'd1, 8'(i));
        add_frame(2'd2, 1'b0, 1'b1, 3'd2, 8'd0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].fv, vecs[i].g);
            chk($sformatf("vec%0d.on", i), is_on, vecs[i].on);
            chk($sformatf("vec%0d.off", i), is_off, vecs[i].off);
            chk($sformatf("vec%0d.state", i), state, vecs[i].st);
            chk($sformatf("vec%0d.count", i), hold_count, vecs[i].cnt);
        end

        // No retrigger across 40 held frames.
        do_reset();
        ons = 0; offs = 0;
        for (int f = 1; f <= 40; f++) begin
            cycle(1'b1, 2'd1);
            ons += int'(is_on); offs += int'(is_off);
            if (f == 8)  chk("hold.state_f8", state, 2);
            if (f == 22) chk("hold.state_f22", state, 2);
            if (f == 23) chk("hold.state_f23", state, 3);
            cycle(1'b0, 2'd1);
            ons += int'(is_on); offs += int'(is_off);
        end
        chk("hold.on_count", ons, 1);
        chk("hold.off_count", offs, 0);
        chk("hold.state_end", state, 3);
        cycle(1'b1, 2'd0);
        chk("hold.release", state, 0);
        ons = 0;
        for (int f = 1; f <= 8; f++) begin
            cycle(1'b1, 2'd1);
            ons += int'(is_on);
            cycle(1'b0, 2'd1);
        end
        chk("hold.second_on", ons, 1);

        // Async reset clears a pulse in flight.
        do_reset();
        for (int f = 1; f <= 7; f++) begin
            cycle(1'b1, 2'd1);
            cycle(1'b0, 2'd1);
        end
        cycle(1'b1, 2'd1);
        chk("arst.pulse_before", is_on, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst.pulse_cleared", is_on, 0);
        chk("arst.pulse_state", state, 0);
        @(negedge clock);
        reset = 1'b1;

        // Async reset mid-cooldown, then a fresh OFF.
        for (int f = 1; f <= 11; f++) begin
            cycle(1'b1, 2'd2);
            cycle(1'b0, 2'd2);
        end
        chk("arst.cool_state", state, 2);
        chk("arst.cool_count", hold_count, 3);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("arst.state", state, 0);
        chk("arst.count", hold_count, 0);
        chk("arst.on_off", {is_on, is_off}, 0);
        @(negedge clock);
        reset = 1'b1;
        offs = 0; ons = 0;
        for (int f = 1; f <= 8; f++) begin
            cycle(1'b1, 2'd2);
            offs += int'(is_off); ons += int'(is_on);
            cycle(1'b0, 2'd2);
            offs += int'(is_off); ons += int'(is_on);
        end
        chk("arst.off_count", offs, 1);
        chk("arst.on_count", ons, 0);
        chk("arst.end_state", state, 2);

        // HOLD_FRAMES=1, COOLDOWN_FRAMES=0 instance.
        do_reset();
        cycle(1'b1, 2'd1);
        chk("min.on", is_on2, 1);
        chk("min.off", is_off2, 0);
        chk("min.state", state2, 3);
        chk("min.count", hold_count2, 0);
        cycle(1'b0, 2'd1);
        chk("min.on_width", is_on2, 0);
        cycle(1'b1, 2'd1);
        chk("min.no_refire", is_on2, 0);
        cycle(1'b1, 2'd3);
        chk("min.release", state2, 0);
        cycle(1'b1, 2'd2);
        chk("min.off", is_off2, 1);
        chk("min.off_state", state2, 3);
        cycle(1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
